// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - state encoding and shared constants for the sequential divider
package div_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_ZERO = 2'd3;

   localparam int DONE_PULSE_LEN = 1;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      CALC = ST_CALC,
      FIX  = ST_FIX,
      ZERO = ST_ZERO
   } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - optional two's-complement negate, used for operand abs and result sign
module div_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_value,
   input  logic             i_neg_en,
   output logic [WIDTH-1:0] o_value
);

   assign o_value = i_neg_en ? ((~i_value) + WIDTH'(1)) : i_value;

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring multi-cycle divider, signed/unsigned, start/busy/done handshake
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_is_signed,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_div_by_zero,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder
);

   div_state_t       r_state;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_dvd;   // dividend bits shift out the top, quotient bits shift in the bottom
   logic [WIDTH-1:0] r_dvs;
   logic [CNT_W-1:0] r_cnt;
   logic             r_q_neg;
   logic             r_r_neg;

   logic [WIDTH-1:0] w_dvd_abs;
   logic [WIDTH-1:0] w_dvs_abs;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_rem_diff;
   logic             w_ge;
   logic [WIDTH-1:0] w_rem_next;
   logic [WIDTH-1:0] w_quo_next;
   logic [WIDTH-1:0] w_quo_fix;
   logic [WIDTH-1:0] w_rem_fix;

   assign w_rem_sh   = {r_rem, r_dvd[WIDTH-1]};
   assign w_rem_diff = w_rem_sh - {1'b0, r_dvs};
   assign w_ge       = ~w_rem_diff[WIDTH];
   assign w_rem_next = w_ge ? w_rem_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
   assign w_quo_next = {r_dvd[WIDTH-2:0], w_ge};

   div_sign_fix #(.WIDTH(WIDTH)) u_abs_dvd (
      .i_value (i_dividend),
      .i_neg_en(i_is_signed & i_dividend[WIDTH-1]),
      .o_value (w_dvd_abs)
   );

   div_sign_fix #(.WIDTH(WIDTH)) u_abs_dvs (
      .i_value (i_divisor),
      .i_neg_en(i_is_signed & i_divisor[WIDTH-1]),
      .o_value (w_dvs_abs)
   );

   // Results are corrected from the final iteration's values so done lands in the FIX cycle.
   div_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
      .i_value (w_quo_next),
      .i_neg_en(r_q_neg),
      .o_value (w_quo_fix)
   );

   div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
      .i_value (w_rem_next),
      .i_neg_en(r_r_neg),
      .o_value (w_rem_fix)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= IDLE;
         r_rem         <= '0;
         r_dvd         <= '0;
         r_dvs         <= '0;
         r_cnt         <= '0;
         r_q_neg       <= 1'b0;
         r_r_neg       <= 1'b0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_div_by_zero <= 1'b0;
         o_quotient    <= '0;
         o_remainder   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               o_done <= 1'b0;
               if (i_start) begin
                  if (i_divisor == '0) begin
                     r_state       <= ZERO;
                     o_done        <= 1'b1;
                     o_div_by_zero <= 1'b1;
                     o_quotient    <= '1;
                     o_remainder   <= i_dividend;
                  end else begin
                     r_state       <= CALC;
                     o_busy        <= 1'b1;
                     o_div_by_zero <= 1'b0;
                     r_dvd         <= w_dvd_abs;
                     r_dvs         <= w_dvs_abs;
                     r_rem         <= '0;
                     r_cnt         <= '0;
                     r_q_neg       <= i_is_signed & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
                     r_r_neg       <= i_is_signed & i_dividend[WIDTH-1];
                  end
               end
            end
            CALC: begin
               r_rem <= w_rem_next;
               r_dvd <= w_quo_next;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(WIDTH - 1)) begin
                  r_state     <= FIX;
                  o_done      <= 1'b1;
                  o_quotient  <= w_quo_fix;
                  o_remainder <= w_rem_fix;
               end
            end
            FIX: begin
               o_done  <= 1'b0;
               o_busy  <= 1'b0;
               r_state <= IDLE;
            end
            ZERO: begin
               o_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider at WIDTH 32 and 8
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_start, s_sgn;
   logic [31:0] s_dvd, s_dvs;
   logic        busy32, done32, dbz32;
   logic [31:0] q32, r32;
   logic        t_start, t_sgn;
   logic [7:0]  t_dvd, t_dvs;
   logic        busy8, done8, dbz8;
   logic [7:0]  q8, r8;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(32)) dut32 (
      .i_clk(clk), .i_reset(rst), .i_start(s_start), .i_is_signed(s_sgn),
      .i_dividend(s_dvd), .i_divisor(s_dvs), .o_busy(busy32), .o_done(done32),
      .o_div_by_zero(dbz32), .o_quotient(q32), .o_remainder(r32)
   );

   seq_divider #(.WIDTH(8)) dut8 (
      .i_clk(clk), .i_reset(rst), .i_start(t_start), .i_is_signed(t_sgn),
      .i_dividend(t_dvd), .i_divisor(t_dvs), .o_busy(busy8), .o_done(done8),
      .o_div_by_zero(dbz8), .o_quotient(q8), .o_remainder(r8)
   );

   // Returns one sample after the edge that captured start; operands are then scrambled.
   task automatic start32(input logic sg, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      s_start = 1'b1; s_sgn = sg; s_dvd = a; s_dvs = b;
      @(posedge clk); #1;
      s_start = 1'b0; s_sgn = ~sg; s_dvd = 32'hDEAD_BEEF; s_dvs = 32'h0;
   endtask

   task automatic wait32(output int lat, output int bc);
      lat = 1; bc = 0;
      while (done32 !== 1'b1 && lat < 200) begin
         bc += int'(busy32 === 1'b1);
         @(posedge clk); #1;
         lat++;
      end
      bc += int'(busy32 === 1'b1);
   endtask

   task automatic start8(input logic sg, input logic [7:0] a, input logic [7:0] b);
      @(posedge clk); #1;
      t_start = 1'b1; t_sgn = sg; t_dvd = a; t_dvs = b;
      @(posedge clk); #1;
      t_start = 1'b0; t_sgn = ~sg; t_dvd = 8'h5A; t_dvs = 8'h0;
   endtask

   task automatic wait8(output int lat, output int bc);
      lat = 1; bc = 0;
      while (done8 !== 1'b1 && lat < 100) begin
         bc += int'(busy8 === 1'b1);
         @(posedge clk); #1;
         lat++;
      end
      bc += int'(busy8 === 1'b1);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy32); end
      n_tests++; if (done32 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done32); end
      n_tests++; if (dbz32 !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", dbz32); end
      n_tests++; if (q32 !== 32'h0 || r32 !== 32'h0) begin n_fail++; $display("FAIL reset_qr: got %h/%h want 0/0", q32, r32); end
      n_tests++; if (q8 !== 8'h0 || busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_w8: got q=%h busy=%b want 0/0", q8, busy8); end
      rst = 1'b0;
   endtask

   task automatic test_unsigned;
      int lat, bc;
      start32(1'b0, 32'd100, 32'd7);
      wait32(lat, bc);
      n_tests++; if (lat != 33) begin n_fail++; $display("FAIL u_latency: got %0d want 33", lat); end
      n_tests++; if (q32 !== 32'd14 || r32 !== 32'd2) begin n_fail++; $display("FAIL u_100_7: got %0d r%0d want 14 r2", q32, r32); end
      n_tests++; if (dbz32 !== 1'b0) begin n_fail++; $display("FAIL u_dbz: got %b want 0", dbz32); end
      n_tests++; if (bc != 33) begin n_fail++; $display("FAIL u_busy_cycles: got %0d want 33", bc); end
      @(posedge clk); #1;
      n_tests++; if (done32 !== 1'b0 || busy32 !== 1'b0) begin n_fail++; $display("FAIL u_after_done: got done=%b busy=%b want 0/0", done32, busy32); end
   endtask

   task automatic test_signed;
      int lat, bc;
      start32(1'b1, 32'hFFFF_FF9C, 32'd7);
      wait32(lat, bc);
      n_tests++; if (q32 !== 32'hFFFF_FFF2 || r32 !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL s_m100_7: got %h r%h want fffffff2 rfffffffe", q32, r32); end
      start32(1'b1, 32'd100, 32'hFFFF_FFF9);
      wait32(lat, bc);
      n_tests++; if (q32 !== 32'hFFFF_FFF2 || r32 !== 32'd2) begin n_fail++; $display("FAIL s_100_m7: got %h r%h want fffffff2 r00000002", q32, r32); end
      n_tests++; if (lat != 33) begin n_fail++; $display("FAIL s_latency: got %0d want 33", lat); end
   endtask

   task automatic test_boundaries;
      int lat, bc;
      start32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait32(lat, bc);
      n_tests++; if (q32 !== 32'h8000_0000 || r32 !== 32'h0) begin n_fail++; $display("FAIL b_min_m1: got %h r%h want 80000000 r0", q32, r32); end
      n_tests++; if (dbz32 !== 1'b0) begin n_fail++; $display("FAIL b_min_m1_dbz: got %b want 0", dbz32); end
      start32(1'b0, 32'hFFFF_FFFF, 32'd2);
      wait32(lat, bc);
      n_tests++; if (q32 !== 32'h7FFF_FFFF || r32 !== 32'd1) begin n_fail++; $display("FAIL b_umax_2: got %h r%h want 7fffffff r1", q32, r32); end
   endtask

   task automatic test_div_by_zero;
      int lat, bc;
      start32(1'b0, 32'd1234, 32'd0);
      wait32(lat, bc);
      n_tests++; if (lat != 1) begin n_fail++; $display("FAIL z_latency: got %0d want 1", lat); end
      n_tests++; if (dbz32 !== 1'b1) begin n_fail++; $display("FAIL z_flag: got %b want 1", dbz32); end
      n_tests++; if (q32 !== 32'hFFFF_FFFF || r32 !== 32'd1234) begin n_fail++; $display("FAIL z_result: got %h r%0d want ffffffff r1234", q32, r32); end
      n_tests++; if (bc != 0) begin n_fail++; $display("FAIL z_busy: got %0d busy cycles want 0", bc); end
      @(posedge clk); #1;
      n_tests++; if (done32 !== 1'b0 || dbz32 !== 1'b1) begin n_fail++; $display("FAIL z_hold: got done=%b dbz=%b want 0/1", done32, dbz32); end
      start32(1'b0, 32'd9, 32'd3);
      n_tests++; if (dbz32 !== 1'b0 || q32 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL z_clear: got dbz=%b q=%h want 0/ffffffff", dbz32, q32); end
      wait32(lat, bc);
      n_tests++; if (q32 !== 32'd3 || r32 !== 32'd0) begin n_fail++; $display("FAIL z_next: got %0d r%0d want 3 r0", q32, r32); end
   endtask

   task automatic test_back_to_back;
      int lat, bc;
      start32(1'b0, 32'd100, 32'd7);
      repeat (4) @(posedge clk);
      #1;
      s_start = 1'b1; s_sgn = 1'b0; s_dvd = 32'd50; s_dvs = 32'd5;
      @(posedge clk); #1;
      s_start = 1'b0;
      wait32(lat, bc);
      n_tests++; if (lat != 28) begin n_fail++; $display("FAIL h_latency: got %0d want 28", lat); end
      n_tests++; if (q32 !== 32'd14 || r32 !== 32'd2) begin n_fail++; $display("FAIL h_ignored: got %0d r%0d want 14 r2", q32, r32); end
      s_start = 1'b1; s_dvd = 32'd60; s_dvs = 32'd7;
      @(posedge clk); #1;
      n_tests++; if (busy32 !== 1'b0 || done32 !== 1'b0) begin n_fail++; $display("FAIL h_fix_start: got busy=%b done=%b want 0/0", busy32, done32); end
      s_dvd = 32'd63; s_dvs = 32'd9;
      @(posedge clk); #1;
      s_start = 1'b0;
      n_tests++; if (busy32 !== 1'b1) begin n_fail++; $display("FAIL h_accept: got busy=%b want 1", busy32); end
      wait32(lat, bc);
      n_tests++; if (lat != 33 || q32 !== 32'd7 || r32 !== 32'd0) begin n_fail++; $display("FAIL h_b2b: got lat=%0d %0d r%0d want 33 7 r0", lat, q32, r32); end
   endtask

   task automatic test_reset_mid;
      int lat, bc, seen;
      start32(1'b0, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_tests++; if (busy32 !== 1'b0 || done32 !== 1'b0 || dbz32 !== 1'b0) begin n_fail++; $display("FAIL m_flags: got busy=%b done=%b dbz=%b want 000", busy32, done32, dbz32); end
      n_tests++; if (q32 !== 32'h0 || r32 !== 32'h0) begin n_fail++; $display("FAIL m_results: got %h/%h want 0/0", q32, r32); end
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         seen += int'(done32 === 1'b1 || busy32 === 1'b1);
      end
      n_tests++; if (seen != 0) begin n_fail++; $display("FAIL m_no_done: got %0d active cycles want 0", seen); end
      start32(1'b0, 32'd9, 32'd3);
      wait32(lat, bc);
      n_tests++; if (lat != 33 || q32 !== 32'd3 || r32 !== 32'd0) begin n_fail++; $display("FAIL m_9_3: got lat=%0d %0d r%0d want 33 3 r0", lat, q32, r32); end
   endtask

   task automatic test_width8;
      int lat, bc;
      start8(1'b0, 8'd200, 8'd3);
      wait8(lat, bc);
      n_tests++; if (lat != 9) begin n_fail++; $display("FAIL w8_latency: got %0d want 9", lat); end
      n_tests++; if (bc != 9) begin n_fail++; $display("FAIL w8_busy: got %0d want 9", bc); end
      n_tests++; if (q8 !== 8'd66 || r8 !== 8'd2) begin n_fail++; $display("FAIL w8_200_3: got %0d r%0d want 66 r2", q8, r8); end
      start8(1'b1, 8'h80, 8'hFF);
      wait8(lat, bc);
      n_tests++; if (q8 !== 8'h80 || r8 !== 8'h00) begin n_fail++; $display("FAIL w8_min_m1: got %h r%h want 80 r00", q8, r8); end
      start8(1'b1, 8'hF9, 8'd2);
      wait8(lat, bc);
      n_tests++; if (q8 !== 8'hFD || r8 !== 8'hFF) begin n_fail++; $display("FAIL w8_m7_2: got %h r%h want fd rff", q8, r8); end
      n_tests++; if (dbz8 !== 1'b0 || dbz32 !== 1'b0) begin n_fail++; $display("FAIL w8_dbz: got %b/%b want 0/0", dbz8, dbz32); end
   endtask

   initial begin
      rst = 1'b1;
      s_start = 1'b0; s_sgn = 1'b0; s_dvd = '0; s_dvs = '0;
      t_start = 1'b0; t_sgn = 1'b0; t_dvd = '0; t_dvs = '0;
      test_reset();
      test_unsigned();
      test_signed();
      test_boundaries();
      test_div_by_zero();
      test_back_to_back();
      test_reset_mid();
      test_width8();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised multi-cycle integer divider for the MIPS datapath. Successor to the fixed 32-bit signed divider; feeds HI/LO (quotient to LO, remainder to HI).
- Adds:
  - generic WIDTH;
  - signed/unsigned mode per operation, covering DIV and DIVU;
  - explicit start/busy/done handshake;
  - deterministic divide-by-zero and overflow results.
- The control FSM stalls on busy and captures results on done.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values 4 to 64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
- dividend  in  WIDTH  sampled with start.
- divisor  in  WIDTH  sampled with start.
- busy  out  1  high while an operation is in flight (CALC, FIX).
- done  out  1  one-cycle pulse; results valid from this cycle.
- div_by_zero  out  1  set at done when divisor was 0; held until next accepted start.
- quotient  out  WIDTH  result; held until next done.
- remainder  out  WIDTH  result; held until next done.

Behaviour:
- Reset (synchronous; wins over every other input, including mid-operation):
  - state to IDLE;
  - busy, done, div_by_zero, quotient, remainder to 0;
  - any operation in flight is discarded and done is never pulsed for it.
- States: IDLE, CALC, FIX, ZERO.
- IDLE, start=1, divisor==0: go to ZERO.
- IDLE, start=1, divisor!=0:
  - latch magnitudes |dividend| and |divisor| (abs applied only if is_signed);
  - latch q_neg = is_signed & (sign(dividend) ^ sign(divisor));
  - latch r_neg = is_signed & sign(dividend);
  - clear partial remainder (WIDTH+1 bits) and counter;
  - go to CALC.
- CALC: one restoring iteration per cycle.
  - rem = {rem[WIDTH-1:0], dvd_msb}; shift dividend register left.
  - If rem >= divisor: subtract and shift a 1 into the quotient, else shift a 0.
  - After WIDTH iterations (counter == WIDTH-1 on the last one), go to FIX.
- FIX:
  - quotient = q_neg ? -q : q; remainder = r_neg ? -r : r (truncating division; remainder takes the dividend's sign);
  - done=1 for this cycle;
  - next state IDLE.
- ZERO:
  - div_by_zero=1, done=1 for one cycle;
  - quotient = all ones, remainder = dividend as sampled;
  - next state IDLE;
  - busy stays 0 throughout.
- Latency:
  - normal: start edge to done cycle = WIDTH+1 cycles; busy is high for WIDTH+1 cycles;
  - divide-by-zero: 1 cycle.
- Handshake and holding rules:
  - start while busy, or in the FIX/ZERO cycle, is ignored (no queueing).
  - start is accepted again in the cycle after done.
  - Inputs may change freely after the start cycle.
  - Outputs are stable between done pulses; a new accepted start does not clear quotient or remainder until its own done.
  - div_by_zero clears on the next accepted start.
- Signed overflow: MIN / -1 yields quotient=MIN, remainder=0. This is the natural wrap; no flag is raised.
- Arithmetic:
  - negation is two's complement at WIDTH bits;
  - magnitude of MIN is handled as an unsigned WIDTH-bit value, with no loss;
  - the partial remainder uses WIDTH+1 bits so the compare never overflows.

Decomposition:
- Package div_pkg holds:
  - state enum (IDLE, CALC, FIX, ZERO);
  - WIDTH-independent localparams: state encoding, DONE_PULSE_LEN=1.
- One sub-module: div_sign_fix, a combinational magnitude/negate helper.
  - Inputs: value, neg_en. Output: neg_en ? -value : value.
  - Instanced for operand abs and result correction.

Test Plan:
- Unsigned, W=32: 100 / 7 -> done after 33 cycles; quotient=14, remainder=2, div_by_zero=0, busy high 33 cycles.
- Signed: -100 / 7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Then 100 / -7 -> quotient=-14, remainder=2.
- Boundaries:
  - signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0;
  - unsigned 0xFFFFFFFF / 2 -> quotient=0x7FFFFFFF, remainder=1.
- Divide by zero: 1234 / 0 -> done and div_by_zero=1 on the next cycle, quotient=0xFFFFFFFF, remainder=1234, busy never high. The next valid start clears div_by_zero.
- Handshake: start re-pulsed with different operands 5 cycles into an operation -> ignored; results match the first operation. Start in the cycle after done -> accepted.
- Reset at cycle 10 of 33 -> next cycle state IDLE, all outputs 0, no done pulse. A new 9 / 3 then gives 3 r0. Repeat the run with WIDTH=8: 200 / 3 unsigned -> 66 r2 in 9 cycles.
